// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_ctrl;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_ctrl;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;

    logic              rsp_valid;
    logic              rsp_id;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;

    modport slave (
        input  req0_valid, req0_ctrl, req0_a, req0_b,
        input  req1_valid, req1_ctrl, req1_a, req1_b,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_ctrl, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_err, rsp_data
    );

    modport master (
        output req0_valid, req0_ctrl, req0_a, req0_b,
        output req1_valid, req1_ctrl, req1_a, req1_b,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_ctrl, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_err, rsp_data
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters with a one-entry tagged response register.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 win every tie instead of alternating.
module alu_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_arbiter_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic              rsp_id;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              last_grant;
`endif

    logic              gnt_valid;
    logic              gnt_id;
    logic              space;
    logic              accept;
    logic              legal;
    logic [3:0]        sel_ctrl;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    always_comb begin
        gnt_valid = bus.req0_valid | bus.req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
        gnt_id = ~bus.req0_valid;
`else
        // On a tie the requester that did not win last time goes next.
        gnt_id = (bus.req0_valid & bus.req1_valid) ? ~last_grant : ~bus.req0_valid;
`endif
        space    = ~rst_i & ((state == EMPTY) | bus.rsp_ready);
        accept   = gnt_valid & space;
        sel_ctrl = gnt_id ? bus.req1_ctrl : bus.req0_ctrl;
        sel_a    = gnt_id ? bus.req1_a    : bus.req0_a;
        sel_b    = gnt_id ? bus.req1_b    : bus.req0_b;
        legal    = (sel_ctrl <= 4'd8);
    end

    assign bus.req0_ready = accept & ~gnt_id;
    assign bus.req1_ready = accept &  gnt_id;
    assign bus.alu_ctrl   = (accept & legal) ? sel_ctrl : '0;
    assign bus.alu_a      = accept ? sel_a : '0;
    assign bus.alu_b      = accept ? sel_b : '0;

    assign bus.rsp_valid  = (state == FULL);
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_err    = rsp_err;
    assign bus.rsp_data   = rsp_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= EMPTY;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else if (accept) begin
            state      <= FULL;
            rsp_id     <= gnt_id;
            rsp_err    <= ~legal;
            rsp_data   <= legal ? bus.alu_result : '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= gnt_id;
`endif
        end else if ((state == FULL) && bus.rsp_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic checked against a cycle model.
module tb_alu_arbiter;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(W)) bus();
    alu_arbiter #(.DATA_W(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return a ^ b;
            4'd4: return a >> b[4:0];
            4'd5: return W'($signed(a) >>> b[4:0]);
            4'd6: return a | b;
            4'd7: return a & b;
            4'd8: return a << 12;
            default: return '0;
        endcase
    endfunction

    // Stand-in for the shared ALU.
    always_comb bus.alu_result = ref_alu(bus.alu_ctrl, bus.alu_a, bus.alu_b);

    bit         m_full, m_id, m_err, m_last;
    logic [W-1:0] m_data;
    bit         p_acc, p_g, p_legal;
    logic [W-1:0] p_res;
    logic       obs_r0, obs_r1;
    logic [3:0] obs_ctrl;
    int         n_assert = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit space, h0, h1;
        logic [3:0] c;
        logic [W-1:0] a, b;
        @(negedge clk);
        h0 = bus.req0_valid;
        h1 = bus.req1_valid;
        space = !rst && (!m_full || bus.rsp_ready);
        if (h0 && h1) p_g = FIXED ? 1'b0 : !m_last;
        else          p_g = !h0;
        p_acc   = space && (h0 || h1);
        c       = p_g ? bus.req1_ctrl : bus.req0_ctrl;
        a       = p_g ? bus.req1_a : bus.req0_a;
        b       = p_g ? bus.req1_b : bus.req0_b;
        p_legal = (c < 4'd9);
        p_res   = ref_alu(c, a, b);
        obs_r0  = bus.req0_ready;
        obs_r1  = bus.req1_ready;
        obs_ctrl = bus.alu_ctrl;
        check("req0_ready", obs_r0, W'(p_acc && !p_g));
        check("req1_ready", obs_r1, W'(p_acc && p_g));
        check("alu_ctrl", bus.alu_ctrl, (p_acc && p_legal) ? W'(c) : '0);
        check("alu_a", bus.alu_a, p_acc ? a : '0);
        check("alu_b", bus.alu_b, p_acc ? b : '0);
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_id = 0; m_err = 0; m_data = '0; m_last = 1;
        end else if (p_acc) begin
            m_full = 1; m_id = p_g; m_err = !p_legal;
            m_data = p_legal ? p_res : '0;
            m_last = p_g;
        end else if (m_full && bus.rsp_ready) begin
            m_full = 0;
        end
        #1;
        check("rsp_valid", bus.rsp_valid, W'(m_full));
        check("rsp_id", bus.rsp_id, W'(m_id));
        check("rsp_err", bus.rsp_err, W'(m_err));
        check("rsp_data", bus.rsp_data, m_data);
    endtask

    task automatic set_req(input int unsigned n, input logic v, input logic [3:0] c,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic rand_req(input int unsigned n);
        logic [3:0] c;
        c = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
        set_req(n, ($urandom_range(0, 3) != 0), c, $urandom, $urandom);
    endtask

    logic [W-1:0] alt_exp [4];

    initial begin
        // Reset with both requesters active: nothing may be accepted.
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(0, 1, 4'd0, 32'd1, 32'd1);
        set_req(1, 1, 4'd0, 32'd2, 32'd2);
        cycle();
        check("rst_rsp_valid", bus.rsp_valid, '0);
        rst = 1'b0;
        set_req(1, 0, 4'd0, '0, '0);

        // Single add.
        set_req(0, 1, 4'd0, 32'd5, 32'd7);
        cycle();
        check("add_ready", obs_r0, 32'd1);
        check("add_data", bus.rsp_data, 32'd12);
        check("add_id", bus.rsp_id, 32'd0);
        set_req(0, 0, 4'd0, '0, '0);

        // Both valid continuously after a fresh reset.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        if (FIXED) alt_exp = '{32'd7, 32'd7, 32'd7, 32'd7};
        else       alt_exp = '{32'd7, 32'hFF, 32'd7, 32'hFF};
        set_req(0, 1, 4'd1, 32'd10, 32'd3);
        set_req(1, 1, 4'd3, 32'hF0, 32'h0F);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("alt_data%0d", i), bus.rsp_data, alt_exp[i]);
        end

        // Stall with req1 waiting, then drain and accept in the same cycle.
        set_req(0, 1, 4'd0, 32'd1, 32'd2);
        cycle();
        check("stall_pre_r0", obs_r0, 32'd1);
        set_req(0, 0, 4'd0, '0, '0);
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("stall_r1_%0d", i), obs_r1, 32'd0);
            check($sformatf("stall_data%0d", i), bus.rsp_data, 32'd3);
        end
        bus.rsp_ready = 1'b1;
        cycle();
        check("drain_r1", obs_r1, 32'd1);
        check("drain_data", bus.rsp_data, 32'hFF);
        check("drain_id", bus.rsp_id, 32'd1);

        // Illegal code from req1, then a legal op clears the error.
        set_req(1, 1, 4'b1011, 32'd1, 32'd2);
        cycle();
        check("ill_ctrl", W'(obs_ctrl), 32'd0);
        check("ill_err", bus.rsp_err, 32'd1);
        check("ill_data", bus.rsp_data, 32'd0);
        check("ill_id", bus.rsp_id, 32'd1);
        set_req(1, 0, 4'd0, '0, '0);
        set_req(0, 1, 4'd0, 32'd4, 32'd4);
        cycle();
        check("clr_err", bus.rsp_err, 32'd0);
        check("clr_data", bus.rsp_data, 32'd8);

        // lui and sra.
        set_req(0, 1, 4'd8, 32'h0000_0ABC, 32'd3);
        cycle();
        check("lui", bus.rsp_data, 32'h00AB_C000);
        set_req(0, 1, 4'd5, 32'h8000_0000, 32'd4);
        cycle();
        check("sra", bus.rsp_data, 32'hF800_0000);

        // Reset while FULL with both requesters valid.
        set_req(0, 1, 4'd0, 32'd9, 32'd9);
        bus.rsp_ready = 1'b0;
        cycle();
        set_req(1, 1, 4'd6, 32'h3, 32'h4);
        rst = 1'b1;
        cycle();
        check("rstf_r0", obs_r0, 32'd0);
        check("rstf_r1", obs_r1, 32'd0);
        check("rstf_valid", bus.rsp_valid, 32'd0);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        cycle();
        check("tie_after_rst", obs_r0, 32'd1);

        // Random traffic; requesters hold until accepted.
        for (int i = 0; i < 500; i++) begin
            if (!bus.req0_valid || (p_acc && !p_g)) rand_req(0);
            if (!bus.req1_valid || (p_acc && p_g))  rand_req(1);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
